// File: rtl/sram_port_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_port_ctrl_if
//   Command / response channel between core logic and one sram_port_ctrl.
//
//   Command channel (master -> slave, valid/ready):
//     cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wmask   master drives
//     cmd_ready                                            slave drives
//   Response channel (slave -> master, valid/ready, reads only):
//     rsp_valid, rsp_rdata                                 slave drives
//     rsp_ready                                            master drives
//
//   Modports:
//     master - core-side requester
//     slave  - the SRAM port controller
// ----------------------------------------------------------------------------
interface sram_port_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] cmd_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output cmd_valid,
    output cmd_we,
    output cmd_addr,
    output cmd_wdata,
    output cmd_wmask,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  cmd_valid,
    input  cmd_we,
    input  cmd_addr,
    input  cmd_wdata,
    input  cmd_wmask,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface : sram_port_ctrl_if

// File: rtl/sram_port_ctrl.sv
// ----------------------------------------------------------------------------
// sram_port_ctrl
//   Responder-side controller for one gf180mcu_fd_ip_sram__sram512x8m8wm1
//   macro. Accepts read/write commands on a valid/ready channel, drives the
//   macro's active-low control pins in the cycle a command is accepted, and
//   returns read data through a 3-entry in-order response FIFO.
//
//   Ports:
//     clk        clock, also the macro CLK
//     rst_n      asynchronous active-low reset
//     bus        sram_port_ctrl_if.slave (cmd_* in, cmd_ready out,
//                rsp_valid/rsp_rdata out, rsp_ready in)
//     init_done  controller is accepting commands
//     sram_cen   macro CEN  (active-low chip enable)
//     sram_gwen  macro GWEN (active-low global write enable)
//     sram_wen   macro WEN  (per-bit active-low write enable)
//     sram_a     macro address
//     sram_d     macro write data
//     sram_q     macro read data, valid after the edge that captured a read
//
//   Optional feature (compile-time macro SRAM_INIT_CLEAR_EN):
//     When defined, the controller comes out of reset in an INIT state and
//     writes zero to every word of the macro, one word per cycle, before it
//     raises init_done and starts accepting commands. When undefined, the
//     controller is ready straight out of reset and macro contents are
//     undefined until written.
//
//   Flow control: a read is only accepted while the buffered responses plus
//   the read currently inside the macro stay below the FIFO depth, so the
//   FIFO can never overflow. The ready decision uses registered state and
//   cmd_we only; rsp_ready never reaches cmd_ready combinationally.
// ----------------------------------------------------------------------------
module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_ctrl_if.slave       bus,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  // Response FIFO holds three words; pointers wrap 0 -> 1 -> 2 -> 0.
  localparam logic [1:0] FIFO_LAST  = 2'd2;
  localparam logic [2:0] CREDIT_MAX = 3'd3;

  // Next FIFO pointer with wrap at the last slot.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    logic [1:0] nxt;
    if (ptr == FIFO_LAST) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_mem_r [0:2];
  logic [1:0]            wr_ptr_r;
  logic [1:0]            rd_ptr_r;
  logic [1:0]            fifo_count_r;
  logic                  rd_inflight_r;

  logic [2:0]            credit_s;
  logic                  cmd_ready_s;
  logic                  cmd_fire_s;
  logic                  rd_fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  init_active_s;
  logic [ADDR_WIDTH-1:0] init_addr_s;

`ifdef SRAM_INIT_CLEAR_EN
  // --------------------------------------------------------------------------
  // Power-on clear: walk every address once, writing zero, then run.
  // --------------------------------------------------------------------------
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] INIT_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  init_done_r;

  // Clear sequencer FSM; reset during INIT restarts from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == INIT_LAST) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            init_cnt_r  <= init_cnt_r + INIT_STEP;
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= {ADDR_WIDTH{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign init_done     = init_done_r;
  assign init_active_s = (state_r == ST_INIT);
  assign init_addr_s   = init_cnt_r;
`else
  // No clear pass: ready from the first cycle after reset.
  assign init_done     = 1'b1;
  assign init_active_s = 1'b0;
  assign init_addr_s   = {ADDR_WIDTH{1'b0}};
`endif

  // --------------------------------------------------------------------------
  // Command handshake
  // --------------------------------------------------------------------------

  // Credit check and handshake strobes; writes never need a credit.
  always_comb begin
    credit_s = {1'b0, fifo_count_r} + {2'b00, rd_inflight_r};
    if (!init_done) begin
      cmd_ready_s = 1'b0;
    end else if (bus.cmd_we) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = (credit_s < CREDIT_MAX);
    end
    cmd_fire_s = bus.cmd_valid && cmd_ready_s;
    rd_fire_s  = cmd_fire_s && !bus.cmd_we;
    // The macro output is valid one edge after the read was captured.
    push_s     = rd_inflight_r;
    pop_s      = (fifo_count_r != 2'd0) && bus.rsp_ready;
  end

  assign bus.cmd_ready = cmd_ready_s;

  // --------------------------------------------------------------------------
  // Macro pins: driven combinationally in the cycle of the accepted command
  // so the macro captures it on the same edge that completes the handshake.
  // --------------------------------------------------------------------------

  // Macro pin mux: clear pass, accepted command, or idle.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = {DATA_WIDTH{1'b1}};
    sram_a    = {ADDR_WIDTH{1'b0}};
    sram_d    = {DATA_WIDTH{1'b0}};
    if (init_active_s) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = {DATA_WIDTH{1'b0}};
      sram_a    = init_addr_s;
      sram_d    = {DATA_WIDTH{1'b0}};
    end else if (cmd_fire_s) begin
      sram_cen = 1'b0;
      sram_a   = bus.cmd_addr;
      if (bus.cmd_we) begin
        sram_gwen = 1'b0;
        sram_wen  = ~bus.cmd_wmask;
        sram_d    = bus.cmd_wdata;
      end else begin
        sram_gwen = 1'b1;
        sram_wen  = {DATA_WIDTH{1'b1}};
        sram_d    = {DATA_WIDTH{1'b0}};
      end
    end else begin
      sram_cen = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline and response FIFO
  // --------------------------------------------------------------------------

  // Marks a read whose data appears on sram_q after the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight_r <= 1'b0;
    end else begin
      rd_inflight_r <= rd_fire_s;
    end
  end

  // Response FIFO storage and pointers; simultaneous push and pop both land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= sram_q;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // FIFO occupancy; the credit rule keeps it at or below three.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
        2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  assign bus.rsp_valid = (fifo_count_r != 2'd0);
  assign bus.rsp_rdata = fifo_mem_r[rd_ptr_r];

endmodule : sram_port_ctrl
